// File: rtl/stream_config.sv
// stream_config: shared byte-stream sizing constants and helpers
package stream_config;

    localparam int BYTE_WIDTH = 8;

    // Number of stream words needed to carry width bits (ceiling division)
    function automatic int num_bytes(input int width, input int bw = BYTE_WIDTH);
        return (width + bw - 1) / bw;
    endfunction

endpackage

// File: rtl/byte_stream_packer.sv
// byte_stream_packer: packs a byte-serial stream, first byte most significant, into PKT_WIDTH packets
module byte_stream_packer #(
    parameter int PKT_WIDTH  = 16,
    parameter int BYTE_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  byte_valid,
    output logic                  byte_ready,
    input  logic [BYTE_WIDTH-1:0] byte_in,
    input  logic                  flush,
    output logic                  pkt_valid,
    input  logic                  pkt_ready,
    output logic [PKT_WIDTH-1:0]  pkt,
    output logic                  partial
);
    import stream_config::*;

    localparam int NUM_BYTES = num_bytes(PKT_WIDTH, BYTE_WIDTH);
    localparam int SW        = NUM_BYTES * BYTE_WIDTH;
    localparam int CW        = NUM_BYTES > 1 ? $clog2(NUM_BYTES) : 1;

    typedef logic [CW-1:0] cnt_t;

    cnt_t          cnt;
    logic [SW-1:0] shift;
    logic [SW-1:0] shift_nxt;
    logic          last;
    logic          byte_acc;
    logic          pkt_acc;

    assign last       = cnt == cnt_t'(NUM_BYTES - 1);
    assign byte_ready = !rst && !flush && !(last && pkt_valid && !pkt_ready);
    assign byte_acc   = byte_valid && byte_ready;
    assign pkt_acc    = pkt_valid && pkt_ready;
    assign shift_nxt  = SW'({shift, byte_in});
    assign partial    = cnt != '0;

    // Assembly state: flush restarts the packet, each accepted byte shifts in at the low end
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            cnt   <= '0;
            shift <= '0;
        end else if (byte_acc) begin
            cnt   <= last ? '0 : cnt + 1'b1;
            shift <= shift_nxt;
        end
    end

    // Output register: a completing byte loads a packet (even while the old one drains), an accept empties it
    always_ff @(posedge clk) begin
        if (rst) begin
            pkt       <= '0;
            pkt_valid <= 1'b0;
        end else if (byte_acc && last) begin
            pkt       <= PKT_WIDTH'(shift_nxt);
            pkt_valid <= 1'b1;
        end else if (pkt_acc) begin
            pkt_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_byte_stream_packer.sv
// tb_byte_stream_packer: scoreboard bench over four packer widths (12, 16, 8, 20 bits)
module tb_byte_stream_packer;

    typedef struct packed {
        logic [1:0]  id;
        logic [31:0] v;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] bv  = '0;
    logic [3:0] pr  = '0;
    logic [3:0] fl  = '0;
    wire  [3:0] br;
    wire  [3:0] pv;
    wire  [3:0] pa;
    logic [7:0] bi [4];
    wire  [11:0] pk12;
    wire  [15:0] pk16;
    wire  [7:0]  pk8;
    wire  [19:0] pk20;
    logic [31:0] pk [4];

    exp_t sb [$];
    exp_t mon_e;
    int   n_chk  = 0;
    int   n_fail = 0;
    int   n_pop  = 0;

    assign pk[0] = 32'(pk12);
    assign pk[1] = 32'(pk16);
    assign pk[2] = 32'(pk8);
    assign pk[3] = 32'(pk20);

    byte_stream_packer #(.PKT_WIDTH(12)) u12 (
        .clk(clk), .rst(rst), .byte_valid(bv[0]), .byte_ready(br[0]), .byte_in(bi[0]),
        .flush(fl[0]), .pkt_valid(pv[0]), .pkt_ready(pr[0]), .pkt(pk12), .partial(pa[0]));
    byte_stream_packer #(.PKT_WIDTH(16)) u16 (
        .clk(clk), .rst(rst), .byte_valid(bv[1]), .byte_ready(br[1]), .byte_in(bi[1]),
        .flush(fl[1]), .pkt_valid(pv[1]), .pkt_ready(pr[1]), .pkt(pk16), .partial(pa[1]));
    byte_stream_packer #(.PKT_WIDTH(8)) u8 (
        .clk(clk), .rst(rst), .byte_valid(bv[2]), .byte_ready(br[2]), .byte_in(bi[2]),
        .flush(fl[2]), .pkt_valid(pv[2]), .pkt_ready(pr[2]), .pkt(pk8), .partial(pa[2]));
    byte_stream_packer #(.PKT_WIDTH(20)) u20 (
        .clk(clk), .rst(rst), .byte_valid(bv[3]), .byte_ready(br[3]), .byte_in(bi[3]),
        .flush(fl[3]), .pkt_valid(pv[3]), .pkt_ready(pr[3]), .pkt(pk20), .partial(pa[3]));

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every packet handshake pops the scoreboard and compares instance and value
    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (!rst && pv[i] && pr[i]) begin
                n_pop++;
                if (sb.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL pkt dut%0d: got %0h expected none", i, pk[i]);
                end else begin
                    mon_e = sb.pop_front();
                    chk($sformatf("pkt dut%0d", i), {2'(i), pk[i]}, mon_e);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        foreach (bi[i]) bi[i] = '0;
        // reset
        @(negedge clk);
        chk("rst ready low", br, 4'h0);
        nxt();
        nxt();
        rst = 1'b0;
        @(negedge clk);
        chk("rst valid", pv, 4'h0);
        chk("rst partial", pa, 4'h0);
        chk("rst ready", br, 4'hF);
        chk("rst pkt16", pk[1], 32'h0);
        nxt();

        // 12-bit: A5,3C -> 53C
        pr[0] = 1; bv[0] = 1; bi[0] = 8'hA5;
        @(negedge clk);
        chk("t1 ready b0", br[0], 1);
        nxt();
        bi[0] = 8'h3C; sb.push_back({2'd0, 32'h53C});
        @(negedge clk);
        chk("t1 ready b1", br[0], 1);
        chk("t1 valid early", pv[0], 0);
        nxt();
        bv[0] = 0;
        @(negedge clk);
        chk("t1 valid", pv[0], 1);
        chk("t1 pkt", pk[0], 32'h53C);
        nxt();
        @(negedge clk);
        chk("t1 valid drop", pv[0], 0);
        nxt();
        pr[0] = 0;

        // 16-bit backpressure: 12,34 held, 56 accepted, 78 stalled
        bv[1] = 1; bi[1] = 8'h12;
        nxt();
        bi[1] = 8'h34; sb.push_back({2'd1, 32'h1234});
        nxt();
        bi[1] = 8'h56;
        @(negedge clk);
        chk("t2 held valid", pv[1], 1);
        chk("t2 held pkt", pk[1], 32'h1234);
        chk("t2 ready nonfinal", br[1], 1);
        nxt();
        bi[1] = 8'h78;
        @(negedge clk);
        chk("t2 partial", pa[1], 1);
        chk("t2 stall", br[1], 0);
        nxt();
        @(negedge clk);
        chk("t2 stall2", br[1], 0);
        chk("t2 stable pkt", pk[1], 32'h1234);
        nxt();
        pr[1] = 1; sb.push_back({2'd1, 32'h5678});
        @(negedge clk);
        chk("t2 ready release", br[1], 1);
        nxt();
        pr[1] = 0; bv[1] = 0;
        @(negedge clk);
        chk("t2 valid kept", pv[1], 1);
        chk("t2 new pkt", pk[1], 32'h5678);
        chk("t2 partial clr", pa[1], 0);
        nxt();
        pr[1] = 1;
        nxt();
        pr[1] = 0;
        @(negedge clk);
        chk("t2 drained", pv[1], 0);
        nxt();

        // 16-bit flush: AA, flush with BB offered, then CC,DD
        pr[1] = 1; bv[1] = 1; bi[1] = 8'hAA;
        nxt();
        fl[1] = 1; bi[1] = 8'hBB;
        @(negedge clk);
        chk("t3 flush ready", br[1], 0);
        chk("t3 partial before", pa[1], 1);
        nxt();
        fl[1] = 0; bi[1] = 8'hCC;
        @(negedge clk);
        chk("t3 partial after", pa[1], 0);
        nxt();
        bi[1] = 8'hDD; sb.push_back({2'd1, 32'hCCDD});
        nxt();
        bv[1] = 0;
        @(negedge clk);
        chk("t3 pkt", pk[1], 32'hCCDD);
        nxt();
        pr[1] = 0;

        // 16-bit reset with held packet and partial byte
        bv[1] = 1; bi[1] = 8'h12;
        nxt();
        bi[1] = 8'h34;
        nxt();
        bi[1] = 8'h56;
        nxt();
        bv[1] = 0;
        @(negedge clk);
        chk("t4 partial pre", pa[1], 1);
        chk("t4 valid pre", pv[1], 1);
        nxt();
        rst = 1;
        @(negedge clk);
        chk("t4 ready in rst", br, 4'h0);
        nxt();
        rst = 0;
        @(negedge clk);
        chk("t4 valid", pv[1], 0);
        chk("t4 pkt", pk[1], 32'h0);
        chk("t4 partial", pa[1], 0);
        chk("t4 ready", br[1], 1);
        nxt();
        pr[1] = 1; bv[1] = 1; bi[1] = 8'h9A;
        nxt();
        bi[1] = 8'hBC; sb.push_back({2'd1, 32'h9ABC});
        nxt();
        bv[1] = 0;
        @(negedge clk);
        chk("t4 new pkt", pk[1], 32'h9ABC);
        nxt();
        pr[1] = 0;

        // 8-bit: one packet per byte, never partial
        pr[2] = 1; bv[2] = 1;
        for (int i = 1; i <= 16; i++) begin
            bi[2] = 8'(i);
            sb.push_back({2'd2, 32'(i)});
            @(negedge clk);
            chk($sformatf("t5 partial %0d", i), pa[2], 0);
            chk($sformatf("t5 ready %0d", i), br[2], 1);
            if (i > 1) chk($sformatf("t5 valid %0d", i), pv[2], 1);
            nxt();
        end
        bv[2] = 0;
        nxt();
        pr[2] = 0;

        // 20-bit: FF,12,34 -> F1234
        pr[3] = 1; bv[3] = 1; bi[3] = 8'hFF;
        nxt();
        bi[3] = 8'h12;
        @(negedge clk);
        chk("t6 partial1", pa[3], 1);
        nxt();
        bi[3] = 8'h34; sb.push_back({2'd3, 32'hF1234});
        @(negedge clk);
        chk("t6 partial2", pa[3], 1);
        nxt();
        bv[3] = 0;
        @(negedge clk);
        chk("t6 pkt", pk[3], 32'hF1234);
        chk("t6 partial0", pa[3], 0);
        nxt();
        pr[3] = 0;

        repeat (3) nxt();
        chk("scoreboard empty", 64'(sb.size()), 0);
        chk("packet count", 64'(n_pop), 22);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
